// File: rtl/equiv_pkg.sv
// Shared types and constants for the equivalence monitor.
package equiv_pkg;

    // Window controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Default width of the length field and of every counter.
    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/equiv_monitor_ctrl_sat_cnt.sv
// Next-value logic for a saturating up-counter with synchronous clear.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic [W-1:0] cnt_q,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt_d
);

    // Clear wins over increment; an all-ones count holds instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/equiv_monitor_ctrl.sv
// Compares two signals over a timed window, counting matches and mismatches,
// recording the first mismatch index and flagging runs of consecutive misses.
module equiv_monitor_ctrl
    import equiv_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int MAX_MISS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] sig_a,
    input  logic [WIDTH-1:0] sig_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail,
    output logic             first_fail_vld,
    output logic             error
);

    localparam logic [CNT_W-1:0] MAX_MISS_C = CNT_W'(MAX_MISS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             pass_inc;
    logic             fail_inc;

    sat_cnt #(.W(CNT_W)) u_pass_cnt (
        .cnt_q (pass_q),
        .inc   (pass_inc),
        .clr   (cnt_clr),
        .cnt_d (pass_d)
    );

    sat_cnt #(.W(CNT_W)) u_fail_cnt (
        .cnt_q (fail_q),
        .inc   (fail_inc),
        .clr   (cnt_clr),
        .cnt_d (fail_d)
    );

    // Next-state and datapath: open a window on start, sample each RUN cycle, pulse done in REPORT.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        ff_d     = ff_q;
        ffv_d    = ffv_q;
        err_d    = err_q;
        run_d    = run_q;
        cnt_clr  = 1'b0;
        pass_inc = 1'b0;
        fail_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    len_d   = len;
                    idx_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    err_d   = 1'b0;
                    run_d   = '0;
                    state_d = (len == '0) ? REPORT : RUN;
                end
            end
            RUN: begin
                if (sig_a == sig_b) begin
                    pass_inc = 1'b1;
                    run_d    = '0;
                end else begin
                    fail_inc = 1'b1;
                    if (run_q != '1) begin
                        run_d = run_q + CNT_W'(1);
                    end
                    if (!ffv_q) begin
                        ff_d  = idx_q;
                        ffv_d = 1'b1;
                    end
                    if (run_d >= MAX_MISS_C) begin
                        err_d = 1'b1;
                    end
                end
                idx_d = idx_q + CNT_W'(1);
                if (stop || (idx_q == len_q - CNT_W'(1))) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == REPORT);
    end

    // State and output registers; reset aborts any window without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            err_q   <= err_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;
    assign error          = err_q;

endmodule

// File: tb/tb_equiv_monitor_ctrl.sv
// Directed, table-driven bench for equiv_monitor_ctrl plus multi-cycle corner sequences.
module tb_equiv_monitor_ctrl;

    typedef struct {
        logic [15:0] len;
        int          stop_idx;
        logic [15:0] a;
        logic [15:0] b;
        int          e_pass;
        int          e_fail;
        int          e_ff;
        bit          e_ffv;
        bit          e_err;
        int          e_cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [15:0] len;
    logic [0:0]  sig_a, sig_b;
    logic        busy, done, first_fail_vld, error;
    logic [15:0] pass_cnt, fail_cnt, first_fail;

    logic        start3, stop3;
    logic [2:0]  len3;
    logic [0:0]  a3, b3;
    logic        busy3, done3, ffv3, err3;
    logic [2:0]  pass3, fail3, ff3;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    int done_pulses3 = 0;

    vec_t vecs[7];

    equiv_monitor_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .len            (len),
        .sig_a          (sig_a),
        .sig_b          (sig_b),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld),
        .error          (error)
    );

    equiv_monitor_ctrl #(.WIDTH(1), .CNT_W(3), .MAX_MISS(2)) dut3 (
        .clk            (clk),
        .rst            (rst),
        .start          (start3),
        .stop           (stop3),
        .len            (len3),
        .sig_a          (a3),
        .sig_b          (b3),
        .busy           (busy3),
        .done           (done3),
        .pass_cnt       (pass3),
        .fail_cnt       (fail3),
        .first_fail     (ff3),
        .first_fail_vld (ffv3),
        .error          (err3)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Count done pulses of both instances, sampled away from the active edge.
    always @(negedge clk) begin
        if (done)  done_pulses++;
        if (done3) done_pulses3++;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run one window: pulse start, then drive one sample per RUN cycle until busy drops.
    task automatic applyStimulus(input vec_t v, output int cycles, output bit busy_seen);
        @(negedge clk);
        start = 1'b1;
        len   = v.len;
        @(negedge clk);
        start     = 1'b0;
        cycles    = 0;
        busy_seen = 1'b0;
        while (busy && cycles < 20) begin
            busy_seen = 1'b1;
            sig_a = v.a[cycles[3:0]];
            sig_b = v.b[cycles[3:0]];
            stop  = (cycles == v.stop_idx);
            @(negedge clk);
            cycles++;
        end
        sig_a = '0;
        sig_b = '0;
        stop  = 1'b0;
    endtask

    initial begin
        int  cycles;
        bit  busy_seen;
        int  base;
        int  k;

        vecs[0] = '{16'd4,  -1, 16'h0000, 16'h0000, 4, 0, 0, 1'b0, 1'b0, 4};
        vecs[1] = '{16'd6,  -1, 16'h003C, 16'h0030, 4, 2, 2, 1'b1, 1'b1, 6};
        vecs[2] = '{16'd10,  3, 16'h0002, 16'h0000, 3, 1, 1, 1'b1, 1'b0, 4};
        vecs[3] = '{16'd0,  -1, 16'h0000, 16'h0000, 0, 0, 0, 1'b0, 1'b0, 0};
        vecs[4] = '{16'd8,  -1, 16'h0055, 16'h0000, 4, 4, 0, 1'b1, 1'b0, 8};
        vecs[5] = '{16'd1,  -1, 16'h0001, 16'h0000, 0, 1, 0, 1'b1, 1'b0, 1};
        vecs[6] = '{16'd5,   4, 16'h0018, 16'h0000, 3, 2, 3, 1'b1, 1'b1, 5};

        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        len    = '0;
        sig_a  = '0;
        sig_b  = '0;
        start3 = 1'b0;
        stop3  = 1'b0;
        len3   = '0;
        a3     = '0;
        b3     = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_pass", int'(pass_cnt), 0);
        checkOutput("rst_fail", int'(fail_cnt), 0);
        checkOutput("rst_err", int'(error), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            base = done_pulses;
            applyStimulus(vecs[i], cycles, busy_seen);
            checkOutput($sformatf("v%0d_done", i), int'(done), 1);
            checkOutput($sformatf("v%0d_cycles", i), cycles, vecs[i].e_cycles);
            checkOutput($sformatf("v%0d_busy_seen", i), int'(busy_seen), int'(vecs[i].e_cycles > 0));
            checkOutput($sformatf("v%0d_pass", i), int'(pass_cnt), vecs[i].e_pass);
            checkOutput($sformatf("v%0d_fail", i), int'(fail_cnt), vecs[i].e_fail);
            checkOutput($sformatf("v%0d_ffv", i), int'(first_fail_vld), int'(vecs[i].e_ffv));
            checkOutput($sformatf("v%0d_ff", i), int'(first_fail), vecs[i].e_ff);
            checkOutput($sformatf("v%0d_err", i), int'(error), int'(vecs[i].e_err));
            stop = 1'b1;
            repeat (3) @(negedge clk);
            stop = 1'b0;
            #1;
            checkOutput($sformatf("v%0d_idle_busy", i), int'(busy), 0);
            checkOutput($sformatf("v%0d_idle_done", i), int'(done), 0);
            checkOutput($sformatf("v%0d_hold_pass", i), int'(pass_cnt), vecs[i].e_pass);
            checkOutput($sformatf("v%0d_hold_fail", i), int'(fail_cnt), vecs[i].e_fail);
            checkOutput($sformatf("v%0d_pulses", i), done_pulses - base, 1);
        end

        // Reset in the middle of a window with mismatches already recorded.
        base = done_pulses;
        @(negedge clk);
        start = 1'b1;
        len   = 16'd8;
        @(negedge clk);
        start = 1'b0;
        sig_a = 1'b1;
        sig_b = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_fail", int'(fail_cnt), 2);
        checkOutput("mid_err", int'(error), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_fail", int'(fail_cnt), 0);
        checkOutput("async_err", int'(error), 0);
        checkOutput("async_ffv", int'(first_fail_vld), 0);
        @(negedge clk);
        rst   = 1'b0;
        sig_a = '0;
        sig_b = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_no_done", done_pulses - base, 0);
        checkOutput("rst_idle", int'(busy), 0);
        applyStimulus(vecs[0], cycles, busy_seen);
        checkOutput("after_rst_done", int'(done), 1);
        checkOutput("after_rst_pass", int'(pass_cnt), 4);
        checkOutput("after_rst_fail", int'(fail_cnt), 0);

        // Narrow instance: start re-pulsed mid-window and again during REPORT.
        base = done_pulses3;
        @(negedge clk);
        start3 = 1'b1;
        len3   = 3'd7;
        @(negedge clk);
        start3 = 1'b0;
        k = 0;
        while (busy3 && k < 20) begin
            a3     = '0;
            b3     = '0;
            start3 = (k == 3);
            len3   = (k == 3) ? 3'd2 : 3'd7;
            @(negedge clk);
            k++;
        end
        start3 = 1'b0;
        checkOutput("n3_cycles", k, 7);
        checkOutput("n3_done", int'(done3), 1);
        checkOutput("n3_pass", int'(pass3), 7);
        checkOutput("n3_fail", int'(fail3), 0);
        start3 = 1'b1;
        len3   = 3'd3;
        @(negedge clk);
        start3 = 1'b0;
        checkOutput("n3_report_start_busy", int'(busy3), 0);
        checkOutput("n3_done_cleared", int'(done3), 0);
        @(negedge clk);
        checkOutput("n3_still_idle", int'(busy3), 0);
        checkOutput("n3_hold_pass", int'(pass3), 7);
        checkOutput("n3_pulses", done_pulses3 - base, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/equiv_monitor_ctrl.md
EQUIV_MONITOR_CTRL -- requirements
Module: equiv_monitor_ctrl

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 1, the width of each compared signal.
REQ-002 The block SHALL provide parameter CNT_W, default 16, the width of the length field and of every counter.
REQ-003 The block SHALL provide parameter MAX_MISS, default 2, the consecutive-mismatch count that sets error (legal range 1..2^CNT_W-1).
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port start, input, 1 bit: one-cycle pulse that opens a check window.
REQ-008 Port stop, input, 1 bit: aborts a running window early.
REQ-009 Port len, input, CNT_W bits: window length in cycles, sampled when start is accepted.
REQ-010 Port sig_a, input, WIDTH bits: first compared signal.
REQ-011 Port sig_b, input, WIDTH bits: second compared signal.
REQ-012 Port busy, output, 1 bit: high while the FSM is in RUN.
REQ-013 Port done, output, 1 bit: one-cycle pulse marking the end of a window.
REQ-014 Port pass_cnt, output, CNT_W bits: number of samples with sig_a==sig_b.
REQ-015 Port fail_cnt, output, CNT_W bits: number of samples with sig_a!=sig_b.
REQ-016 Port first_fail, output, CNT_W bits: cycle index of the first mismatch in the window.
REQ-017 Port first_fail_vld, output, 1 bit: first_fail holds a valid index.
REQ-018 Port error, output, 1 bit: sticky flag set when consecutive mismatches reach MAX_MISS.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and REPORT.
REQ-020 From IDLE, start=1 with len!=0 SHALL latch len, clear all counters, first_fail_vld and error, and move to RUN.
REQ-021 From IDLE, start=1 with len==0 SHALL clear the same state and move directly to REPORT.
REQ-022 In RUN, each cycle SHALL sample sig_a and sig_b and increment exactly one of pass_cnt or fail_cnt; both counters saturate at all-ones.
REQ-023 The in-window cycle index SHALL be 0 on the first RUN cycle and increment by 1 each RUN cycle.
REQ-024 On the first mismatch in a window, first_fail SHALL take the current cycle index and first_fail_vld SHALL go to 1; later mismatches SHALL not change either.
REQ-025 An internal run counter SHALL increment on each mismatch and clear on each match; when it reaches MAX_MISS, error SHALL set and remain set until the next accepted start.
REQ-026 RUN SHALL move to REPORT after the sample at cycle index len-1, or after any cycle in which stop=1; that cycle's sample is counted.
REQ-027 stop=1 coinciding with the final cycle SHALL produce one transition to REPORT and one done pulse.
REQ-028 REPORT SHALL assert done for exactly one cycle and then move to IDLE.
REQ-029 start during RUN or REPORT SHALL be ignored; stop during IDLE or REPORT SHALL be ignored.
REQ-030 The counter outputs SHALL be registered, and SHALL hold their final values in IDLE until the next accepted start.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE, busy=0, done=0, pass_cnt=0, fail_cnt=0, first_fail=0, first_fail_vld=0, error=0 and clear the run counter.
REQ-032 rst asserted mid-window SHALL abort the window with no done pulse.

Structure
REQ-033 Package equiv_pkg SHALL hold the state enum (IDLE, RUN, REPORT) and the default CNT_W constant.
REQ-034 Saturating increment SHALL be implemented in sub-module sat_cnt, instantiated once each for pass_cnt and fail_cnt.

Verification
REQ-035 Scenario: len=4, sig_a=sig_b=0 for all cycles -> pass_cnt=4, fail_cnt=0, error=0, first_fail_vld=0, done one cycle after index 3.
REQ-036 Scenario: len=6, (a,b) per cycle = (0,0),(0,0),(1,0),(1,0),(1,1),(1,1), MAX_MISS=2 -> pass_cnt=4, fail_cnt=2, first_fail=2, error=1.
REQ-037 Scenario: len=10, stop=1 at index 3 -> done after index 3, pass_cnt+fail_cnt=4.
REQ-038 Scenario: start with len=0 -> done on the next cycle, all counters 0, busy never 1.
REQ-039 Scenario: rst=1 at index 2 of a len=8 window -> outputs 0 asynchronously, no done pulse; a subsequent start runs normally.
REQ-040 Scenario: CNT_W=3, len=7, start pulsed again mid-window -> second start ignored, a single done pulse, pass_cnt=7.
